// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor: operands and start in,
// busy/done status and registered DIFF/BOUT out.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] DIFF;
    logic             BOUT;

    modport master (
        output start, A, B, Bin,
        input  busy, done, DIFF, BOUT
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, DIFF, BOUT
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: DIFF = A - B - Bin, LSB first, through one
// full-subtractor cell and a borrow flop. Results are held until the next start.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] d_sr_shift;

    function automatic logic fs_diff(input logic a, input logic b, input logic bi);
        return a ^ b ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

    // Single full-subtractor cell working on the current LSBs
    assign cell_d     = fs_diff(a_sr_q[0], b_sr_q[0], br_q);
    assign cell_bo    = fs_borrow(a_sr_q[0], b_sr_q[0], br_q);
    assign d_sr_shift = {cell_d, d_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d  = bus.A;
                    b_sr_d  = bus.B;
                    br_d    = bus.Bin;
                    d_sr_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                d_sr_d = d_sr_shift;
                br_d   = cell_bo;
                cnt_d  = cnt_q + CNT_W'(1);
                // Last bit: publish the completed word straight from the shift path
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = d_sr_shift;
                    bout_d  = cell_bo;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.DIFF = diff_q;
    assign bus.BOUT = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random WIDTH=8 operations, busy/start
// interaction, reset abort, back-to-back throughput and a WIDTH=4 exhaustive sweep.
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(8)) i8 ();
    serial_subtractor_if #(.WIDTH(4)) i4 ();

    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(i8.slave));
    serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(i4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain unsigned arithmetic on the operands
    function automatic logic [7:0] ref_diff8(input int a, input int b, input int bin);
        return 8'((a - b - bin + 512) % 256);
    endfunction

    function automatic logic ref_bout(input int a, input int b, input int bin);
        return (a < b + bin);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (i8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy8 got=%b exp=0", i8.busy); end
        checks++; if (i8.done !== 1'b0) begin errors++; $display("FAIL reset_done8 got=%b exp=0", i8.done); end
        checks++; if (i8.DIFF !== 8'h00) begin errors++; $display("FAIL reset_diff8 got=%h exp=00", i8.DIFF); end
        checks++; if (i8.BOUT !== 1'b0) begin errors++; $display("FAIL reset_bout8 got=%b exp=0", i8.BOUT); end
        checks++; if ({i4.busy, i4.done, i4.BOUT, i4.DIFF} !== 7'b0) begin
            errors++; $display("FAIL reset_w4 got=%b exp=0000000", {i4.busy, i4.done, i4.BOUT, i4.DIFF});
        end
        rst = 1'b0;
        tick();
    endtask

    // One WIDTH=8 operation; checks latency, busy length, single done and results
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input string tag);
        int         done_edge = -1;
        int         done_cnt  = 0;
        int         busy_cnt  = 0;
        logic [7:0] diff_at_done = 'x;
        logic       bout_at_done = 1'bx;
        logic [7:0] exp_d = ref_diff8(int'(a), int'(b), int'(bin));
        logic       exp_b = ref_bout(int'(a), int'(b), int'(bin));
        i8.A = a; i8.B = b; i8.Bin = bin; i8.start = 1'b1;
        tick();
        i8.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (i8.busy) busy_cnt++;
            if (i8.done) begin
                done_cnt++;
                done_edge    = k;
                diff_at_done = i8.DIFF;
                bout_at_done = i8.BOUT;
            end
            tick();
        end
        checks++; if (done_edge != 8) begin errors++; $display("FAIL %s_latency got=%0d exp=8", tag, done_edge); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_pulses got=%0d exp=1", tag, done_cnt); end
        checks++; if (busy_cnt != 9) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=9", tag, busy_cnt); end
        checks++; if (diff_at_done !== exp_d) begin errors++; $display("FAIL %s_diff got=%h exp=%h", tag, diff_at_done, exp_d); end
        checks++; if (bout_at_done !== exp_b) begin errors++; $display("FAIL %s_bout got=%b exp=%b", tag, bout_at_done, exp_b); end
        checks++; if ({i8.BOUT, i8.DIFF} !== {exp_b, exp_d}) begin
            errors++; $display("FAIL %s_held got=%b_%h exp=%b_%h", tag, i8.BOUT, i8.DIFF, exp_b, exp_d);
        end
    endtask

    task automatic test_directed();
        run_op8(8'h05, 8'h03, 1'b0, "d_05_03");
        run_op8(8'h03, 8'h05, 1'b0, "d_03_05");
        run_op8(8'h00, 8'h00, 1'b1, "d_00_00_bin");
        run_op8(8'hFF, 8'hFF, 1'b0, "d_ff_ff");
        run_op8(8'h80, 8'h01, 1'b0, "d_80_01");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), "rand");
        end
    endtask

    task automatic test_busy_ignore();
        int done_cnt = 0;
        i8.A = 8'h10; i8.B = 8'h01; i8.Bin = 1'b0; i8.start = 1'b1;
        tick();
        i8.start = 1'b0;
        i8.A = 8'h55;
        for (int k = 0; k < 20; k++) begin
            i8.start = (k == 2 || k == 8);
            if (i8.done) done_cnt++;
            tick();
        end
        i8.start = 1'b0;
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (i8.DIFF !== 8'h0F) begin errors++; $display("FAIL ignore_diff got=%h exp=0f", i8.DIFF); end
        checks++; if (i8.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got=%b exp=0", i8.busy); end
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0;
        i8.A = 8'hC3; i8.B = 8'h21; i8.Bin = 1'b1; i8.start = 1'b1;
        tick();
        i8.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; i8.start = 1'b1;
        tick();
        rst = 1'b0; i8.start = 1'b0;
        checks++; if (i8.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", i8.busy); end
        checks++; if (i8.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", i8.done); end
        checks++; if (i8.DIFF !== 8'h00) begin errors++; $display("FAIL abort_diff got=%h exp=00", i8.DIFF); end
        checks++; if (i8.BOUT !== 1'b0) begin errors++; $display("FAIL abort_bout got=%b exp=0", i8.BOUT); end
        for (int k = 0; k < 15; k++) begin
            if (i8.done || i8.busy) done_cnt++;
            tick();
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_activity got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int         dones = 0;
        int         last  = -1;
        int         bad_gap = 0;
        int         bad_val = 0;
        logic [7:0] a = 8'($urandom);
        logic [7:0] b = 8'($urandom);
        logic [7:0] exp_d = ref_diff8(int'(a), int'(b), 0);
        i8.A = a; i8.B = b; i8.Bin = 1'b0; i8.start = 1'b1;
        tick();
        for (int k = 0; k < 50; k++) begin
            if (i8.done) begin
                dones++;
                if (last >= 0 && k - last != 10) bad_gap++;
                if (i8.DIFF !== exp_d || i8.BOUT !== ref_bout(int'(a), int'(b), 0)) bad_val++;
                last = k;
            end
            tick();
        end
        i8.start = 1'b0;
        repeat (12) tick();
        checks++; if (dones != 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", dones); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_spacing bad_gaps=%0d exp=0", bad_gap); end
        checks++; if (bad_val != 0) begin errors++; $display("FAIL b2b_values bad=%0d exp=0", bad_val); end
    endtask

    task automatic test_exhaustive4();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bin = 0; bin < 2; bin++) begin
                    logic       got = 1'b0;
                    logic [4:0] obs = 'x;
                    logic [4:0] exp = 5'((a - b - bin + 64) % 32);
                    i4.A = 4'(a); i4.B = 4'(b); i4.Bin = 1'(bin); i4.start = 1'b1;
                    tick();
                    i4.start = 1'b0;
                    for (int k = 0; k < 12 && !got; k++) begin
                        if (i4.done) begin
                            got = 1'b1;
                            obs = {i4.BOUT, i4.DIFF};
                        end
                        tick();
                    end
                    checks++;
                    if (!got) begin
                        errors++; $display("FAIL w4_timeout a=%0d b=%0d bin=%0d", a, b, bin);
                    end else if (obs !== exp) begin
                        errors++; $display("FAIL w4_result a=%0d b=%0d bin=%0d got=%b exp=%b", a, b, bin, obs, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        i8.start = 1'b0; i8.A = '0; i8.B = '0; i8.Bin = 1'b0;
        i4.start = 1'b0; i4.A = '0; i4.B = '0; i4.Bin = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_exhaustive4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
